// File: rtl/exp_arbiter.sv
// exp_arbiter: round-robin front end that shares one exponentiation
// engine among NUM_REQ requesters, with a timeout abort path.
module exp_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DEPTH   = 3,
  parameter int TIMEOUT = 64,
  parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*DEPTH-1:0] req_base,
  input  logic [NUM_REQ*DEPTH-1:0] req_exp,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     resp_valid,
  output logic [IDW-1:0]           resp_id,
  output logic [2*DEPTH-1:0]       resp_result,
  output logic                     resp_error,
  output logic                     busy,
  output logic                     eng_start,
  output logic [DEPTH-1:0]         eng_base,
  output logic [DEPTH-1:0]         eng_exp,
  input  logic                     eng_finish,
  input  logic [2*DEPTH-1:0]       eng_result
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    WAIT_DONE,
    RELEASE
  } state_t;

  state_t state, state_d;

  logic [IDW-1:0]     ptr, ptr_d;
  logic [IDW-1:0]     cur_id, cur_id_d;
  logic [TW-1:0]      tcnt, tcnt_d;
  logic [IDW-1:0]     gnt;
  logic               gnt_hit;
  logic [IDW:0]       scan;
  logic               expire;

  logic [NUM_REQ-1:0] req_ready_d;
  logic               resp_valid_d;
  logic [IDW-1:0]     resp_id_d;
  logic [2*DEPTH-1:0] resp_result_d;
  logic               resp_error_d;
  logic               busy_d;
  logic               eng_start_d;
  logic [DEPTH-1:0]   eng_base_d;
  logic [DEPTH-1:0]   eng_exp_d;

  // First valid requester at or above ptr, wrapping.
  always_comb begin
    gnt     = '0;
    gnt_hit = 1'b0;
    scan    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, ptr} + (IDW+1)'(k);
      if (scan >= (IDW+1)'(NUM_REQ))
        scan = scan - (IDW+1)'(NUM_REQ);
      if (!gnt_hit && req_valid[scan[IDW-1:0]]) begin
        gnt     = scan[IDW-1:0];
        gnt_hit = 1'b1;
      end
    end
  end

  assign expire = (tcnt == TW'(TIMEOUT - 1));

  always_comb begin
    state_d       = state;
    ptr_d         = ptr;
    cur_id_d      = cur_id;
    tcnt_d        = tcnt;
    req_ready_d   = '0;
    resp_valid_d  = 1'b0;
    resp_id_d     = resp_id;
    resp_result_d = resp_result;
    resp_error_d  = resp_error;
    eng_start_d   = eng_start;
    eng_base_d    = eng_base;
    eng_exp_d     = eng_exp;
    unique case (state)
      IDLE: begin
        if (gnt_hit) begin
          req_ready_d[gnt] = 1'b1;
          eng_base_d       = req_base[gnt*DEPTH +: DEPTH];
          eng_exp_d        = req_exp[gnt*DEPTH +: DEPTH];
          eng_start_d      = 1'b1;
          cur_id_d         = gnt;
          tcnt_d           = '0;
          ptr_d            = (gnt == IDW'(NUM_REQ - 1)) ?
                             '0 : gnt + 1'b1;
          state_d          = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        tcnt_d = tcnt + 1'b1;
        if (expire) begin
          resp_valid_d  = 1'b1;
          resp_error_d  = 1'b1;
          resp_result_d = '0;
          resp_id_d     = cur_id;
          eng_start_d   = 1'b0;
          state_d       = RELEASE;
        end else if (!eng_finish) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        tcnt_d = tcnt + 1'b1;
        if (eng_finish) begin
          resp_valid_d  = 1'b1;
          resp_error_d  = 1'b0;
          resp_result_d = eng_result;
          resp_id_d     = cur_id;
          eng_start_d   = 1'b0;
          state_d       = RELEASE;
        end else if (expire) begin
          resp_valid_d  = 1'b1;
          resp_error_d  = 1'b1;
          resp_result_d = '0;
          resp_id_d     = cur_id;
          eng_start_d   = 1'b0;
          state_d       = RELEASE;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ptr         <= '0;
      cur_id      <= '0;
      tcnt        <= '0;
      req_ready   <= '0;
      resp_valid  <= 1'b0;
      resp_id     <= '0;
      resp_result <= '0;
      resp_error  <= 1'b0;
      busy        <= 1'b0;
      eng_start   <= 1'b0;
      eng_base    <= '0;
      eng_exp     <= '0;
    end else begin
      state       <= state_d;
      ptr         <= ptr_d;
      cur_id      <= cur_id_d;
      tcnt        <= tcnt_d;
      req_ready   <= req_ready_d;
      resp_valid  <= resp_valid_d;
      resp_id     <= resp_id_d;
      resp_result <= resp_result_d;
      resp_error  <= resp_error_d;
      busy        <= busy_d;
      eng_start   <= eng_start_d;
      eng_base    <= eng_base_d;
      eng_exp     <= eng_exp_d;
    end
  end

endmodule

// File: tb/tb_exp_arbiter.sv
// tb_exp_arbiter: directed bench for exp_arbiter with a small
// start/finish exponentiation engine model.
module tb_exp_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [11:0] req_base = '0;
  logic [11:0] req_exp = '0;
  logic [3:0]  req_ready;
  logic        resp_valid;
  logic [1:0]  resp_id;
  logic [5:0]  resp_result;
  logic        resp_error;
  logic        busy;
  logic        eng_start;
  logic [2:0]  eng_base;
  logic [2:0]  eng_exp;
  logic        eng_finish;
  logic [5:0]  eng_result;

  int ncmp = 0;
  int nfail = 0;
  longint acc_t = 0;
  longint acc_dt = 0;
  bit stuck = 1'b0;

  exp_arbiter #(
    .NUM_REQ(4),
    .DEPTH(3),
    .TIMEOUT(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_base(req_base),
    .req_exp(req_exp),
    .req_ready(req_ready),
    .resp_valid(resp_valid),
    .resp_id(resp_id),
    .resp_result(resp_result),
    .resp_error(resp_error),
    .busy(busy),
    .eng_start(eng_start),
    .eng_base(eng_base),
    .eng_exp(eng_exp),
    .eng_finish(eng_finish),
    .eng_result(eng_result)
  );

  always #5 clk = ~clk;

  // Engine model: finish rises exp+2 edges after it sees start,
  // then holds until start drops.
  logic       e_busy;
  logic [3:0] e_cnt;
  logic [2:0] e_b, e_e;

  function automatic logic [5:0] pw(input logic [2:0] b,
                                    input logic [2:0] e);
    logic [5:0] r;
    r = 6'd1;
    for (int i = 0; i < int'(e); i++) r = r * {3'b0, b};
    return r;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_busy     <= 1'b0;
      e_cnt      <= '0;
      e_b        <= '0;
      e_e        <= '0;
      eng_finish <= 1'b0;
      eng_result <= '0;
    end else if (e_busy) begin
      if (eng_finish) begin
        if (!eng_start) begin
          eng_finish <= 1'b0;
          e_busy     <= 1'b0;
        end
      end else if (e_cnt == 0) begin
        eng_finish <= 1'b1;
        eng_result <= pw(e_b, e_e);
      end else begin
        e_cnt <= e_cnt - 1'b1;
      end
    end else if (eng_start && !stuck) begin
      e_busy <= 1'b1;
      e_cnt  <= {1'b0, eng_exp} + 4'd1;
      e_b    <= eng_base;
      e_e    <= eng_exp;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic set_req(input int i, input logic [2:0] b,
                         input logic [2:0] e);
    req_base[i*3 +: 3] = b;
    req_exp[i*3 +: 3]  = e;
  endtask

  task automatic wait_grant(input logic [3:0] m, input bit drop);
    int n;
    n = 0;
    while (req_ready == 4'b0 && n < 300) begin
      tick();
      n++;
    end
    chk("grant", {28'b0, req_ready}, {28'b0, m});
    if (req_ready != 4'b0) begin
      acc_dt = $time - acc_t;
      acc_t  = $time;
    end
    if (drop) req_valid = req_valid & ~req_ready;
  endtask

  task automatic wait_resp(input int id, input int res,
                           input bit err, input int lat);
    int n;
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) chk("ready_pulse", {28'b0, req_ready}, 0);
    end while (!resp_valid && n < 300);
    chk("resp_valid", {31'b0, resp_valid}, 1);
    chk("resp_id", {30'b0, resp_id}, id);
    chk("resp_result", {26'b0, resp_result}, res);
    chk("resp_error", {31'b0, resp_error}, {31'b0, err});
    chk("latency", n, lat);
    chk("start_low", {31'b0, eng_start}, 0);
    tick();
    chk("resp_pulse", {31'b0, resp_valid}, 0);
    chk("idle_busy", {31'b0, busy}, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    #1;
    chk("reset_outs",
        {10'b0, req_ready, resp_valid, resp_id, resp_result,
         resp_error, busy, eng_start, eng_base, eng_exp}, 0);
    tick();
    rst = 1'b1;

    // single request on slot 2
    set_req(2, 3'd3, 3'd2);
    req_valid = 4'b0100;
    wait_grant(4'b0100, 1'b1);
    chk("busy_on", {31'b0, busy}, 1);
    wait_resp(2, 9, 1'b0, 6);

    // all four from reset
    set_req(0, 3'd2, 3'd2);
    set_req(1, 3'd3, 3'd2);
    set_req(2, 3'd4, 3'd2);
    set_req(3, 3'd5, 3'd2);
    req_valid = 4'b1111;
    do_reset();
    wait_grant(4'b0001, 1'b1);
    wait_resp(0, 4, 1'b0, 6);
    wait_grant(4'b0010, 1'b1);
    chk("spacing1", acc_dt[31:0], 80);
    wait_resp(1, 9, 1'b0, 6);
    wait_grant(4'b0100, 1'b1);
    chk("spacing2", acc_dt[31:0], 80);
    wait_resp(2, 16, 1'b0, 6);
    wait_grant(4'b1000, 1'b1);
    chk("spacing3", acc_dt[31:0], 80);
    wait_resp(3, 25, 1'b0, 6);

    // fairness: slots 0 and 3 held continuously
    set_req(0, 3'd2, 3'd1);
    set_req(3, 3'd5, 3'd1);
    req_valid = 4'b1001;
    wait_grant(4'b0001, 1'b0);
    wait_resp(0, 2, 1'b0, 5);
    wait_grant(4'b1000, 1'b0);
    wait_resp(3, 5, 1'b0, 5);
    wait_grant(4'b0001, 1'b0);
    wait_resp(0, 2, 1'b0, 5);
    wait_grant(4'b1000, 1'b0);
    req_valid = 4'b0000;
    wait_resp(3, 5, 1'b0, 5);

    // boundaries
    set_req(1, 3'd7, 3'd0);
    req_valid = 4'b0010;
    wait_grant(4'b0010, 1'b1);
    wait_resp(1, 1, 1'b0, 4);
    set_req(1, 3'd7, 3'd7);
    req_valid = 4'b0010;
    wait_grant(4'b0010, 1'b1);
    wait_resp(1, 55, 1'b0, 11);
    set_req(1, 3'd0, 3'd5);
    req_valid = 4'b0010;
    wait_grant(4'b0010, 1'b1);
    wait_resp(1, 0, 1'b0, 9);

    // timeout with req1 pending behind
    set_req(0, 3'd3, 3'd1);
    set_req(1, 3'd2, 3'd3);
    req_valid = 4'b0011;
    do_reset();
    stuck = 1'b1;
    wait_grant(4'b0001, 1'b1);
    wait_resp(0, 0, 1'b1, 64);
    stuck = 1'b0;
    wait_grant(4'b0010, 1'b1);
    chk("to_regrant", acc_dt[31:0], 660);
    wait_resp(1, 8, 1'b0, 7);

    // async reset during WAIT_DONE
    set_req(2, 3'd3, 3'd5);
    req_valid = 4'b0100;
    wait_grant(4'b0100, 1'b1);
    repeat (4) tick();
    chk("pre_rst_start", {31'b0, eng_start}, 1);
    #3;
    rst = 1'b0;
    #1;
    chk("async_rst_outs",
        {10'b0, req_ready, resp_valid, resp_id, resp_result,
         resp_error, busy, eng_start, eng_base, eng_exp}, 0);
    set_req(1, 3'd3, 3'd1);
    set_req(3, 3'd2, 3'd1);
    req_valid = 4'b1010;
    tick();
    tick();
    chk("rst_no_resp", {31'b0, resp_valid}, 0);
    rst = 1'b1;
    wait_grant(4'b0010, 1'b1);
    wait_resp(1, 3, 1'b0, 5);
    req_valid = 4'b0000;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
